// File: rtl/xu_alu_cr_trap_wb_pkg.sv
// Shared definitions for the ALU CR/trap writeback stage: trap handshake
// state encoding, CR field bit positions and default widths.
// CR bit positions use big-endian numbering, so LT (bit 0) is the MSB of the
// 4-bit field and SO (bit 3) is the LSB, giving {lt,gt,eq,so}.
package xu_alu_cr_trap_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_DRAIN = 2'b10
    } trap_st_t;

    localparam int CR_LT  = 0;
    localparam int CR_GT  = 1;
    localparam int CR_EQ  = 2;
    localparam int CR_SO  = 3;
    localparam int CR_MSB = 3;

    localparam int CR_FLD_W_DEF = 3;
    localparam int TRAP_CNT_W   = 16;

    // Pack compare result {lt,gt,eq} and XER[SO] into a CR field.
    function automatic logic [3:0] cr_field(input logic [2:0] alu_cr, input logic so);
        logic [3:0] f;
        f = '0;
        f[CR_MSB - CR_LT] = alu_cr[2];
        f[CR_MSB - CR_GT] = alu_cr[1];
        f[CR_MSB - CR_EQ] = alu_cr[0];
        f[CR_MSB - CR_SO] = so;
        return f;
    endfunction

endpackage

// File: rtl/xu_alu_cr_trap_wb_trap_fsm.sv
// Single-thread trap request/acknowledge handshake (xu_trap_hs_fsm).
// State | meaning
//   IDLE  | no trap outstanding
//   REQ   | request held to the exception unit, issue held
//   DRAIN | ack seen; issue held one more cycle before returning to IDLE
// A trap entry that arrives while REQ or DRAIN is dropped and latches the
// sticky overflow flag. Optional macro XU_TRAP_CNT_EN adds a saturating
// count of IDLE->REQ transitions.
module xu_trap_hs_fsm
    import xu_alu_cr_trap_wb_pkg::*;
(
    input  logic nclk,
    input  logic rst_b,
    input  logic entry,
    input  logic ack,
    output logic req,
    output logic hold,
    output logic ovf
`ifdef XU_TRAP_CNT_EN
    ,
    output logic [TRAP_CNT_W-1:0] cnt
`endif
);

    trap_st_t state;

    // Handshake state with registered req/hold; ack only matters in REQ.
    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_IDLE;
            req   <= 1'b0;
            hold  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (entry) begin
                        state <= ST_REQ;
                        req   <= 1'b1;
                        hold  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (entry) begin
                        ovf <= 1'b1;
                    end
                    if (ack) begin
                        state <= ST_DRAIN;
                        req   <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (entry) begin
                        ovf <= 1'b1;
                    end
                    state <= ST_IDLE;
                    hold  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    req   <= 1'b0;
                    hold  <= 1'b0;
                end
            endcase
        end
    end

`ifdef XU_TRAP_CNT_EN
    // Count accepted traps, sticking at all-ones.
    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if ((state == ST_IDLE) && entry && (cnt != {TRAP_CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/xu_alu_cr_trap_wb.sv
// ALU CR/trap writeback stage: carries the ex3 compare result and trap flag
// through ex4/ex5, drives the ex5 CR write port and ex4 CR bypass, and runs
// one trap handshake FSM per thread.
// Optional macro XU_TRAP_CNT_EN adds xu_trap_cnt (16-bit per-thread counts,
// thread t at bits [16*t +: 16]).
module xu_alu_cr_trap_wb
    import xu_alu_cr_trap_wb_pkg::*;
#(
    parameter int THREADS  = 2,
    parameter int CR_FLD_W = CR_FLD_W_DEF
) (
    input  logic                nclk,
    input  logic                rst_b,
    input  logic [THREADS-1:0]  ex3_val,
    input  logic [THREADS-1:0]  ex3_flush,
    input  logic [THREADS-1:0]  ex4_flush,
    input  logic [2:0]          ex3_alu_cr,
    input  logic                ex3_trap_val,
    input  logic                ex3_cr_we,
    input  logic [CR_FLD_W-1:0] ex3_cr_fld,
    input  logic                ex3_xer_so,
    output logic [THREADS-1:0]  ex5_cr_we,
    output logic [CR_FLD_W-1:0] ex5_cr_fld,
    output logic [3:0]          ex5_cr_dat,
    output logic                ex4_cr_byp_val,
    output logic [CR_FLD_W-1:0] ex4_cr_byp_fld,
    output logic [3:0]          ex4_cr_byp_dat,
    output logic [THREADS-1:0]  xu_exc_trap_req,
    input  logic [THREADS-1:0]  exc_xu_trap_ack,
    output logic [THREADS-1:0]  xu_iu_trap_hold,
    output logic [THREADS-1:0]  xu_trap_ovf
`ifdef XU_TRAP_CNT_EN
    ,
    output logic [0:TRAP_CNT_W*THREADS-1] xu_trap_cnt
`endif
);

    logic [THREADS-1:0]  valid4;
    logic                cr_we4;
    logic [CR_FLD_W-1:0] cr_fld4;
    logic [3:0]          cr_dat4;
    logic                trap4;

    logic [THREADS-1:0]  valid5;
    logic                cr_we5;
    logic [CR_FLD_W-1:0] cr_fld5;
    logic [3:0]          cr_dat5;
    logic                trap5;

    logic [THREADS-1:0]  trap_entry;

    // ex4 latches: valid tracks ex3 every cycle, payload moves only on a real op.
    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            valid4  <= '0;
            cr_we4  <= 1'b0;
            cr_fld4 <= '0;
            cr_dat4 <= '0;
            trap4   <= 1'b0;
        end else begin
            valid4 <= ex3_val & ~ex3_flush;
            if (|ex3_val) begin
                cr_we4  <= ex3_cr_we;
                cr_fld4 <= ex3_cr_fld;
                cr_dat4 <= cr_field(ex3_alu_cr, ex3_xer_so);
                trap4   <= ex3_trap_val;
            end
        end
    end

    // ex5 latches: last flush point is ex4; payload follows ex4 unconditionally.
    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            valid5  <= '0;
            cr_we5  <= 1'b0;
            cr_fld5 <= '0;
            cr_dat5 <= '0;
            trap5   <= 1'b0;
        end else begin
            valid5  <= valid4 & ~ex4_flush;
            cr_we5  <= cr_we4;
            cr_fld5 <= cr_fld4;
            cr_dat5 <= cr_dat4;
            trap5   <= trap4;
        end
    end

    // CR write port, bypass and trap entry are simple decodes of the latches.
    // Trap ops arrive with cr_we=0 from decode, so the CR write is not gated by trap.
    always_comb begin
        ex5_cr_we      = valid5 & {THREADS{cr_we5}};
        ex5_cr_fld     = cr_fld5;
        ex5_cr_dat     = cr_dat5;
        ex4_cr_byp_val = (|(valid4 & ~ex4_flush)) & cr_we4;
        ex4_cr_byp_fld = cr_fld4;
        ex4_cr_byp_dat = cr_dat4;
        trap_entry     = valid5 & {THREADS{trap5}};
    end

    for (genvar t = 0; t < THREADS; t++) begin : g_thr
        xu_trap_hs_fsm u_trap_fsm (
            .nclk  (nclk),
            .rst_b (rst_b),
            .entry (trap_entry[t]),
            .ack   (exc_xu_trap_ack[t]),
            .req   (xu_exc_trap_req[t]),
            .hold  (xu_iu_trap_hold[t]),
            .ovf   (xu_trap_ovf[t])
`ifdef XU_TRAP_CNT_EN
            ,
            .cnt   (xu_trap_cnt[TRAP_CNT_W*t +: TRAP_CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_xu_alu_cr_trap_wb.sv
// Bench for xu_alu_cr_trap_wb: directed scenarios plus a randomized run
// checked against a cycle-history reference model.
module tb_xu_alu_cr_trap_wb;

    localparam int THREADS  = 2;
    localparam int CR_FLD_W = 3;
    localparam int HMAX     = 4096;

    logic                nclk = 1'b0;
    logic                rst_b = 1'b0;
    logic [THREADS-1:0]  ex3_val = '0;
    logic [THREADS-1:0]  ex3_flush = '0;
    logic [THREADS-1:0]  ex4_flush = '0;
    logic [2:0]          ex3_alu_cr = '0;
    logic                ex3_trap_val = 1'b0;
    logic                ex3_cr_we = 1'b0;
    logic [CR_FLD_W-1:0] ex3_cr_fld = '0;
    logic                ex3_xer_so = 1'b0;
    logic [THREADS-1:0]  exc_xu_trap_ack = '0;
    logic [THREADS-1:0]  ex5_cr_we;
    logic [CR_FLD_W-1:0] ex5_cr_fld;
    logic [3:0]          ex5_cr_dat;
    logic                ex4_cr_byp_val;
    logic [CR_FLD_W-1:0] ex4_cr_byp_fld;
    logic [3:0]          ex4_cr_byp_dat;
    logic [THREADS-1:0]  xu_exc_trap_req;
    logic [THREADS-1:0]  xu_iu_trap_hold;
    logic [THREADS-1:0]  xu_trap_ovf;
`ifdef XU_TRAP_CNT_EN
    logic [0:16*THREADS-1] xu_trap_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    xu_alu_cr_trap_wb #(.THREADS(THREADS), .CR_FLD_W(CR_FLD_W)) dut (
        .nclk            (nclk),
        .rst_b           (rst_b),
        .ex3_val         (ex3_val),
        .ex3_flush       (ex3_flush),
        .ex4_flush       (ex4_flush),
        .ex3_alu_cr      (ex3_alu_cr),
        .ex3_trap_val    (ex3_trap_val),
        .ex3_cr_we       (ex3_cr_we),
        .ex3_cr_fld      (ex3_cr_fld),
        .ex3_xer_so      (ex3_xer_so),
        .ex5_cr_we       (ex5_cr_we),
        .ex5_cr_fld      (ex5_cr_fld),
        .ex5_cr_dat      (ex5_cr_dat),
        .ex4_cr_byp_val  (ex4_cr_byp_val),
        .ex4_cr_byp_fld  (ex4_cr_byp_fld),
        .ex4_cr_byp_dat  (ex4_cr_byp_dat),
        .xu_exc_trap_req (xu_exc_trap_req),
        .exc_xu_trap_ack (exc_xu_trap_ack),
        .xu_iu_trap_hold (xu_iu_trap_hold),
        .xu_trap_ovf     (xu_trap_ovf)
`ifdef XU_TRAP_CNT_EN
        ,
        .xu_trap_cnt     (xu_trap_cnt)
`endif
    );

    always #5 nclk = ~nclk;

    // ---------------- reference model ----------------
    // Every sampled input set is recorded by clock-edge number; expected
    // outputs are derived from that history (ex3 op at edge n is written
    // from ex5 after edge n+1, flushable by ex3_flush at n and ex4_flush at n+1).
    typedef struct packed {
        logic [THREADS-1:0]  val;
        logic [THREADS-1:0]  f3;
        logic [THREADS-1:0]  f4;
        logic [2:0]          alu;
        logic                trap;
        logic                we;
        logic [CR_FLD_W-1:0] fld;
        logic                so;
    } rec_t;

    rec_t hist [0:HMAX-1];
    int   cyc = 0;
    int   rst_mark = 0;
    int   mst  [THREADS];   // 0 idle, 1 requesting, 2 draining
    bit   movf [THREADS];
    int   mcnt [THREADS];
    rec_t mrec;
    logic [THREADS-1:0] ment;

    function automatic rec_t h(input int i);
        rec_t r;
        r = '0;
        if (i > rst_mark && i < HMAX) r = hist[i];
        return r;
    endfunction

    // Most recent op with any thread valid at or before edge n (payload holder).
    function automatic rec_t last_op(input int n);
        for (int i = n; i > rst_mark; i--) begin
            if (i < HMAX && hist[i].val != '0) return hist[i];
        end
        return '0;
    endfunction

    // Thread valids sitting in ex5 after edge n.
    function automatic logic [THREADS-1:0] v5_at(input int n);
        rec_t a, b;
        a = h(n - 1);
        b = h(n);
        return a.val & ~a.f3 & ~b.f4;
    endfunction

    always @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            rst_mark = cyc;
            for (int t = 0; t < THREADS; t++) begin
                mst[t] = 0; movf[t] = 1'b0; mcnt[t] = 0;
            end
        end else begin
            ment = v5_at(cyc) & {THREADS{last_op(cyc - 1).trap}};
            cyc++;
            mrec.val = ex3_val;      mrec.f3 = ex3_flush;   mrec.f4 = ex4_flush;
            mrec.alu = ex3_alu_cr;   mrec.trap = ex3_trap_val;
            mrec.we = ex3_cr_we;     mrec.fld = ex3_cr_fld; mrec.so = ex3_xer_so;
            if (cyc < HMAX) hist[cyc] = mrec;
            for (int t = 0; t < THREADS; t++) begin
                case (mst[t])
                    0: if (ment[t]) begin
                        mst[t] = 1;
                        if (mcnt[t] < 65535) mcnt[t]++;
                    end
                    1: begin
                        if (ment[t]) movf[t] = 1'b1;
                        if (exc_xu_trap_ack[t]) mst[t] = 2;
                    end
                    default: begin
                        if (ment[t]) movf[t] = 1'b1;
                        mst[t] = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge nclk);
        @(negedge nclk);
    endtask

    task automatic clear_inputs();
        ex3_val = '0; ex3_flush = '0; ex4_flush = '0; ex3_alu_cr = '0;
        ex3_trap_val = 1'b0; ex3_cr_we = 1'b0; ex3_cr_fld = '0; ex3_xer_so = 1'b0;
        exc_xu_trap_ack = '0;
    endtask

    task automatic drive_op(input logic [THREADS-1:0] val, input logic [2:0] alu,
                            input logic trap, input logic we,
                            input logic [CR_FLD_W-1:0] fld, input logic so);
        ex3_val = val; ex3_alu_cr = alu; ex3_trap_val = trap;
        ex3_cr_we = we; ex3_cr_fld = fld; ex3_xer_so = so;
    endtask

    task automatic drive_trap(input logic [THREADS-1:0] val);
        drive_op(val, 3'b100, 1'b1, 1'b0, '0, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst_b = 1'b0;
        tick(); tick();
        #1;
        n_cmp++;
        if ({ex5_cr_we, ex5_cr_fld, ex5_cr_dat, ex4_cr_byp_val, ex4_cr_byp_fld, ex4_cr_byp_dat} !== '0) begin
            n_err++;
            $display("FAIL reset_cr: got we=%b fld=%0d dat=%b byp=%b bfld=%0d bdat=%b, want all 0",
                     ex5_cr_we, ex5_cr_fld, ex5_cr_dat, ex4_cr_byp_val, ex4_cr_byp_fld, ex4_cr_byp_dat);
        end
        n_cmp++;
        if ({xu_exc_trap_req, xu_iu_trap_hold, xu_trap_ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_trap: got req=%b hold=%b ovf=%b, want 0", xu_exc_trap_req, xu_iu_trap_hold, xu_trap_ovf);
        end
        @(negedge nclk);
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_cr_write();
        drive_op(2'b10, 3'b010, 1'b0, 1'b1, 3'd3, 1'b1);
        tick();
        clear_inputs();
        #1;
        n_cmp++;
        if ({ex4_cr_byp_val, ex4_cr_byp_fld, ex4_cr_byp_dat} !== {1'b1, 3'd3, 4'b0101}) begin
            n_err++;
            $display("FAIL cr_bypass: got val=%b fld=%0d dat=%b, want 1/3/0101", ex4_cr_byp_val, ex4_cr_byp_fld, ex4_cr_byp_dat);
        end
        n_cmp++;
        if (ex5_cr_we !== 2'b00) begin
            n_err++;
            $display("FAIL cr_early: ex5_cr_we got %b want 00 one cycle after ex3", ex5_cr_we);
        end
        tick();
        #1;
        n_cmp++;
        if ({ex5_cr_we, ex5_cr_fld, ex5_cr_dat} !== {2'b10, 3'd3, 4'b0101}) begin
            n_err++;
            $display("FAIL cr_write: got we=%b fld=%0d dat=%b, want 10/3/0101", ex5_cr_we, ex5_cr_fld, ex5_cr_dat);
        end
        n_cmp++;
        if (ex4_cr_byp_val !== 1'b0) begin
            n_err++;
            $display("FAIL cr_bypass_clr: got %b want 0", ex4_cr_byp_val);
        end
        tick();
        #1;
        n_cmp++;
        if (ex5_cr_we !== 2'b00) begin
            n_err++;
            $display("FAIL cr_write_once: ex5_cr_we got %b want 00", ex5_cr_we);
        end
    endtask

    task automatic test_ex4_flush();
        drive_op(2'b10, 3'b010, 1'b0, 1'b1, 3'd3, 1'b1);
        tick();
        clear_inputs();
        ex4_flush = 2'b10;
        #1;
        n_cmp++;
        if (ex4_cr_byp_val !== 1'b0) begin
            n_err++;
            $display("FAIL flush_bypass: got %b want 0", ex4_cr_byp_val);
        end
        tick();
        ex4_flush = '0;
        #1;
        n_cmp++;
        if (ex5_cr_we !== 2'b00) begin
            n_err++;
            $display("FAIL flush_write: ex5_cr_we got %b want 00", ex5_cr_we);
        end
        tick();
    endtask

    task automatic test_trap_ack();
        int reqc, holdc, first;
        reqc = 0; holdc = 0; first = -1;
        drive_trap(2'b01);
        tick();
        clear_inputs();
        for (int i = 0; i < 20; i++) begin
            #1;
            if (xu_exc_trap_req[0]) begin
                if (first < 0) first = i;
                reqc++;
            end
            if (xu_iu_trap_hold[0]) holdc++;
            exc_xu_trap_ack = (xu_exc_trap_req[0] && reqc == 5) ? 2'b01 : 2'b00;
            tick();
        end
        exc_xu_trap_ack = '0;
        n_cmp++;
        if (first != 2) begin
            n_err++;
            $display("FAIL trap_latency: req first seen at cycle %0d, want 2", first);
        end
        n_cmp++;
        if (reqc != 5) begin
            n_err++;
            $display("FAIL trap_req_len: req high %0d cycles, want 5", reqc);
        end
        n_cmp++;
        if (holdc != 6) begin
            n_err++;
            $display("FAIL trap_hold_len: hold high %0d cycles, want 6", holdc);
        end
    endtask

    task automatic test_trap_ovf();
        int rises;
        logic prev;
        rises = 0;
        drive_trap(2'b01);
        tick();
        clear_inputs();
        tick(); tick();
        #1;
        n_cmp++;
        if (xu_exc_trap_req[0] !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_req: req[0] got %b want 1", xu_exc_trap_req[0]);
        end
        prev = xu_exc_trap_req[0];
        drive_trap(2'b01);
        tick();
        clear_inputs();
        for (int i = 0; i < 6; i++) begin
            #1;
            if (xu_exc_trap_req[0] && !prev) rises++;
            prev = xu_exc_trap_req[0];
            tick();
        end
        n_cmp++;
        if (xu_trap_ovf !== 2'b01) begin
            n_err++;
            $display("FAIL ovf_flag: got %b want 01", xu_trap_ovf);
        end
        exc_xu_trap_ack = 2'b01;
        tick();
        exc_xu_trap_ack = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (xu_exc_trap_req[0] && !prev) rises++;
            prev = xu_exc_trap_req[0];
            tick();
        end
        n_cmp++;
        if (rises != 0 || xu_iu_trap_hold !== 2'b00) begin
            n_err++;
            $display("FAIL ovf_single_req: extra req rises %0d hold %b, want 0 and 00", rises, xu_iu_trap_hold);
        end
        n_cmp++;
        if (xu_trap_ovf !== 2'b01) begin
            n_err++;
            $display("FAIL ovf_sticky: got %b want 01", xu_trap_ovf);
        end
    endtask

    task automatic test_dual_trap();
        drive_trap(2'b01);
        tick();
        drive_trap(2'b10);
        tick();
        clear_inputs();
        tick(); tick();
        #1;
        n_cmp++;
        if ({xu_exc_trap_req, xu_iu_trap_hold} !== {2'b11, 2'b11}) begin
            n_err++;
            $display("FAIL dual_req: got req=%b hold=%b want 11/11", xu_exc_trap_req, xu_iu_trap_hold);
        end
        exc_xu_trap_ack = 2'b10;
        tick();
        exc_xu_trap_ack = '0;
        #1;
        n_cmp++;
        if ({xu_exc_trap_req, xu_iu_trap_hold} !== {2'b01, 2'b11}) begin
            n_err++;
            $display("FAIL dual_ack1: got req=%b hold=%b want 01/11", xu_exc_trap_req, xu_iu_trap_hold);
        end
        tick();
        #1;
        n_cmp++;
        if ({xu_exc_trap_req, xu_iu_trap_hold} !== {2'b01, 2'b01}) begin
            n_err++;
            $display("FAIL dual_drain1: got req=%b hold=%b want 01/01", xu_exc_trap_req, xu_iu_trap_hold);
        end
        exc_xu_trap_ack = 2'b01;
        tick();
        exc_xu_trap_ack = '0;
        tick();
        #1;
        n_cmp++;
        if ({xu_exc_trap_req, xu_iu_trap_hold} !== 4'b0000) begin
            n_err++;
            $display("FAIL dual_idle: got req=%b hold=%b want 00/00", xu_exc_trap_req, xu_iu_trap_hold);
        end
    endtask

    task automatic test_random();
        logic [THREADS-1:0] v5, v4, ewe;
        rec_t o5, o4;
        logic ebv;
        int r;
        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, THREADS);
            ex3_val = (r == THREADS) ? '0 : THREADS'(1 << r);
            ex3_flush = ($urandom_range(0, 5) == 0) ? THREADS'($urandom) : '0;
            ex4_flush = ($urandom_range(0, 5) == 0) ? THREADS'($urandom) : '0;
            ex3_alu_cr = 3'($urandom);
            ex3_trap_val = ($urandom_range(0, 6) == 0);
            ex3_cr_we = ex3_trap_val ? 1'b0 : 1'($urandom);
            ex3_cr_fld = CR_FLD_W'($urandom);
            ex3_xer_so = 1'($urandom);
            exc_xu_trap_ack = THREADS'($urandom) & THREADS'($urandom);
            #1;
            v5 = v5_at(cyc);
            o5 = last_op(cyc - 1);
            ewe = v5 & {THREADS{o5.we}};
            n_cmp++;
            if ({ex5_cr_we, ex5_cr_fld, ex5_cr_dat} !== {ewe, o5.fld, o5.alu, o5.so}) begin
                n_err++;
                $display("FAIL rnd_cr_write n=%0d: got we=%b fld=%0d dat=%b want we=%b fld=%0d dat=%b",
                         n, ex5_cr_we, ex5_cr_fld, ex5_cr_dat, ewe, o5.fld, {o5.alu, o5.so});
            end
            v4 = h(cyc).val & ~h(cyc).f3;
            o4 = last_op(cyc);
            ebv = (|(v4 & ~ex4_flush)) & o4.we;
            n_cmp++;
            if ({ex4_cr_byp_val, ex4_cr_byp_fld, ex4_cr_byp_dat} !== {ebv, o4.fld, o4.alu, o4.so}) begin
                n_err++;
                $display("FAIL rnd_bypass n=%0d: got %b/%0d/%b want %b/%0d/%b", n,
                         ex4_cr_byp_val, ex4_cr_byp_fld, ex4_cr_byp_dat, ebv, o4.fld, {o4.alu, o4.so});
            end
            for (int t = 0; t < THREADS; t++) begin
                n_cmp++;
                if ({xu_exc_trap_req[t], xu_iu_trap_hold[t], xu_trap_ovf[t]} !==
                    {mst[t] == 1, mst[t] != 0, movf[t]}) begin
                    n_err++;
                    $display("FAIL rnd_trap n=%0d t=%0d: got req=%b hold=%b ovf=%b want req=%b hold=%b ovf=%b",
                             n, t, xu_exc_trap_req[t], xu_iu_trap_hold[t], xu_trap_ovf[t],
                             mst[t] == 1, mst[t] != 0, movf[t]);
                end
`ifdef XU_TRAP_CNT_EN
                n_cmp++;
                if (xu_trap_cnt[16*t +: 16] !== 16'(mcnt[t])) begin
                    n_err++;
                    $display("FAIL rnd_cnt t=%0d: got %0d want %0d", t, xu_trap_cnt[16*t +: 16], mcnt[t]);
                end
`endif
            end
            tick();
        end
        clear_inputs();
        exc_xu_trap_ack = '1;
        for (int i = 0; i < 8; i++) tick();
        exc_xu_trap_ack = '0;
        tick();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
`ifdef XU_TRAP_CNT_EN
        for (int k = 0; k < 3; k++) begin
            drive_trap(2'b01);
            tick();
            clear_inputs();
            tick(); tick();
            exc_xu_trap_ack = 2'b01;
            tick();
            exc_xu_trap_ack = '0;
            tick();
        end
        #1;
        n_cmp++;
        if (xu_trap_cnt !== {16'd3, 16'd0}) begin
            n_err++;
            $display("FAIL cnt_three: got t0=%0d t1=%0d want 3/0", xu_trap_cnt[0:15], xu_trap_cnt[16:31]);
        end
`endif
        drive_trap(2'b01);
        tick();
        clear_inputs();
        tick(); tick();
        #1;
        n_cmp++;
        if ({xu_exc_trap_req[0], xu_iu_trap_hold[0]} !== 2'b11) begin
            n_err++;
            $display("FAIL arst_pre: got req=%b hold=%b want 1/1", xu_exc_trap_req[0], xu_iu_trap_hold[0]);
        end
        #1;
        rst_b = 1'b0;
        #1;
        n_cmp++;
        if ({xu_exc_trap_req, xu_iu_trap_hold, xu_trap_ovf} !== '0) begin
            n_err++;
            $display("FAIL arst_drop: got req=%b hold=%b ovf=%b want 0 without a clock edge",
                     xu_exc_trap_req, xu_iu_trap_hold, xu_trap_ovf);
        end
`ifdef XU_TRAP_CNT_EN
        n_cmp++;
        if (xu_trap_cnt !== '0) begin
            n_err++;
            $display("FAIL cnt_reset: got t0=%0d t1=%0d want 0", xu_trap_cnt[0:15], xu_trap_cnt[16:31]);
        end
`endif
        @(negedge nclk);
        rst_b = 1'b1;
        tick(); tick(); tick();
        #1;
        n_cmp++;
        if (xu_iu_trap_hold !== 2'b00) begin
            n_err++;
            $display("FAIL arst_idle: hold got %b want 00 after reset release", xu_iu_trap_hold);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge nclk);
        test_reset();
        test_cr_write();
        test_ex4_flush();
        test_trap_ack();
        test_trap_ovf();
        test_dual_trap();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
